// File: rtl/cmd_decoder_if.sv
// Byte-FIFO, register-file, trigger, config and readback signals of the command decoder.
// master drives the FIFO/handshake inputs; slave is the decoder itself.
interface cmd_decoder_if #(
    parameter int NUM_REGS = 4,
    parameter int NUM_TRIG = 4
);
    logic [7:0]            rx_rdata;
    logic                  rx_rempty;
    logic                  ft_busy;
    logic                  rx_rinc;
    logic [NUM_REGS*8-1:0] regs;
    logic [NUM_TRIG-1:0]   trig;
    logic [15:0]           cfg_data;
    logic                  cfg_start;
    logic                  cfg_busy;
    logic [15:0]           rsp_data;
    logic                  rsp_avail;
    logic                  rsp_accept;
    logic                  err;
    logic [7:0]            err_count;

    modport master (
        output rx_rdata, rx_rempty, ft_busy, cfg_busy, rsp_accept,
        input  rx_rinc, regs, trig, cfg_data, cfg_start, rsp_data, rsp_avail, err, err_count
    );

    modport slave (
        input  rx_rdata, rx_rempty, ft_busy, cfg_busy, rsp_accept,
        output rx_rinc, regs, trig, cfg_data, cfg_start, rsp_data, rsp_avail, err, err_count
    );
endinterface

// File: rtl/cmd_decoder.sv
// Serial byte-command decoder: pops opcodes/payload from a FWFT FIFO and drives
// a register file, trigger pulses, a config-word launch and a held readback word.
module cmd_decoder #(
    parameter int NUM_REGS = 4,
    parameter int NUM_TRIG = 4,
    parameter int TRIG_LEN = 2,
    parameter int TIMEOUT  = 65535
) (
    input  logic          clk,
    input  logic          rst_n,
    cmd_decoder_if.slave  bus
);
    localparam int AW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int TIW = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int TLW = $clog2(TRIG_LEN + 1);

    localparam logic [7:0]     OP_SET   = 8'h01;
    localparam logic [7:0]     OP_GET   = 8'h02;
    localparam logic [7:0]     OP_CFG   = 8'h03;
    localparam logic [7:0]     OP_CLR   = 8'hFE;
    localparam logic [7:0]     NREG8    = 8'(NUM_REGS);
    localparam logic [3:0]     NTRIG4   = 4'(NUM_TRIG);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TLW-1:0] TLEN_LAST = TLW'(TRIG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, EVAL, PAY0, PAY1, EXEC, WAIT_CFG, RESP, TRIG
    } state_t;

    state_t                     state_q;
    logic [7:0]                 op_q, b0_q, b1_q;
    logic                       pay_done_q;
    logic [TW-1:0]              tmo_q;
    logic [TLW-1:0]             tlen_q;
    logic [NUM_REGS-1:0][7:0]   regs_q;
    logic [NUM_TRIG-1:0]        trig_q;
    logic [15:0]                cfg_data_q, rsp_data_q;
    logic                       cfg_start_q, rsp_avail_q, err_q;
    logic [7:0]                 err_cnt_q, err_cnt_d;

    logic          fetch, addr_ok, trig_ok;
    logic [AW-1:0] addr_idx;

    assign fetch     = !bus.rx_rempty && !bus.ft_busy;
    assign addr_ok   = b0_q < NREG8;
    assign addr_idx  = b0_q[AW-1:0];
    assign trig_ok   = (op_q[7:4] == 4'h1) && (op_q[3:0] < NTRIG4);
    assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // The pop must be combinational: with a FWFT head the byte is captured in the
    // same cycle it is acknowledged, so a registered pop would lag by one byte.
    assign bus.rx_rinc = rst_n && fetch &&
                         ((state_q == IDLE) || (state_q == PAY0) || (state_q == PAY1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            b0_q        <= '0;
            b1_q        <= '0;
            pay_done_q  <= 1'b0;
            tmo_q       <= '0;
            tlen_q      <= '0;
            regs_q      <= '0;
            trig_q      <= '0;
            cfg_data_q  <= '0;
            cfg_start_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_avail_q <= 1'b0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_q       <= 1'b0;
            cfg_start_q <= 1'b0;
            case (state_q)
                IDLE: if (fetch) begin
                    op_q       <= bus.rx_rdata;
                    pay_done_q <= 1'b0;
                    state_q    <= CMD;
                end
                CMD: state_q <= EVAL;
                // EVAL is visited twice: once to decode the opcode, once after the
                // payload so that SET_REG lands three cycles after its last pop.
                EVAL: begin
                    tmo_q  <= '0;
                    tlen_q <= '0;
                    if (pay_done_q || op_q == OP_CLR) begin
                        state_q <= EXEC;
                    end else if (op_q == OP_SET || op_q == OP_GET || op_q == OP_CFG) begin
                        state_q <= PAY0;
                    end else if (trig_ok) begin
                        trig_q                   <= '0;
                        trig_q[op_q[TIW-1:0]]    <= 1'b1;
                        state_q                  <= TRIG;
                    end else begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= IDLE;
                    end
                end
                PAY0, PAY1: begin
                    if (fetch) begin
                        tmo_q <= '0;
                        if (state_q == PAY0) b0_q <= bus.rx_rdata;
                        else                 b1_q <= bus.rx_rdata;
                        if (state_q == PAY1 || op_q == OP_GET) begin
                            pay_done_q <= 1'b1;
                            state_q    <= EVAL;
                        end else begin
                            state_q <= PAY1;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                EXEC: begin
                    state_q <= IDLE;
                    case (op_q)
                        OP_SET: if (addr_ok) regs_q[addr_idx] <= b1_q;
                                else begin err_q <= 1'b1; err_cnt_q <= err_cnt_d; end
                        OP_GET: if (addr_ok) begin
                                    rsp_data_q  <= {b0_q, regs_q[addr_idx]};
                                    rsp_avail_q <= 1'b1;
                                    state_q     <= RESP;
                                end else begin
                                    err_q <= 1'b1; err_cnt_q <= err_cnt_d;
                                end
                        OP_CFG: state_q <= WAIT_CFG;
                        default: regs_q <= '0;
                    endcase
                end
                WAIT_CFG: if (!bus.cfg_busy) begin
                    cfg_data_q  <= {b0_q, b1_q};
                    cfg_start_q <= 1'b1;
                    state_q     <= IDLE;
                end
                RESP: if (bus.rsp_accept) begin
                    rsp_avail_q <= 1'b0;
                    state_q     <= IDLE;
                end
                TRIG: begin
                    if (tlen_q == TLEN_LAST) begin
                        trig_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        tlen_q <= tlen_q + TLW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.regs      = regs_q;
    assign bus.trig      = trig_q;
    assign bus.cfg_data  = cfg_data_q;
    assign bus.cfg_start = cfg_start_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_avail = rsp_avail_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_cnt_q;
endmodule
